// File: rtl/clock_divert_ctrl.sv
// ============================================================================
// clock_divert_ctrl
// Game clock-enable divider that pauses on divert request edges.
// Revision 1.0
// ============================================================================
`default_nettype none

module clock_divert_ctrl #(
    parameter int DIV         = 4,
    parameter int HOLD_CYCLES = 104160,
    parameter int NCH         = 2,
    parameter int RETRIG      = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [NCH-1:0] divert_req,
    output logic           tick,
    output logic           paused,
    output logic [NCH-1:0] pause_src,
    output logic           resume,
    output logic [7:0]     pause_cnt
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    localparam logic [PW-1:0] c_PRE_MAX   = PW'(DIV - 1);
    localparam logic [PW-1:0] c_PRE_ONE   = PW'(1);
    localparam logic [HW-1:0] c_HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] c_HOLD_ONE  = HW'(1);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HOLD   = 2'd1,
        ST_RESUME = 2'd2
    } state_t;

    state_t         r_state;
    logic [PW-1:0]  r_pre;
    logic [HW-1:0]  r_hold;
    logic [NCH-1:0] r_prev;
    logic [NCH-1:0] r_src;
    logic [7:0]     r_cnt;
    logic           r_paused;

    logic [NCH-1:0] w_edge;
    logic           w_any_edge;
    logic [7:0]     w_cnt_inc;

    assign w_edge     = divert_req & ~r_prev;
    assign w_any_edge = |w_edge;
    assign w_cnt_inc  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;

    // A fresh edge wins over a tick or resume landing in the same cycle.
    assign tick      = (r_state == ST_RUN) && (r_pre == c_PRE_MAX) && !w_any_edge;
    assign resume    = (r_state == ST_RESUME) && !w_any_edge;
    assign paused    = r_paused;
    assign pause_src = r_src;
    assign pause_cnt = r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_pre    <= '0;
            r_hold   <= '0;
            r_prev   <= '0;
            r_src    <= '0;
            r_cnt    <= '0;
            r_paused <= 1'b0;
        end else begin
            r_prev <= divert_req;
            case (r_state)
                ST_RUN: begin
                    if (w_any_edge) begin
                        r_state  <= ST_HOLD;
                        r_paused <= 1'b1;
                        r_hold   <= c_HOLD_LOAD;
                        r_pre    <= '0;
                        r_src    <= w_edge;
                        r_cnt    <= w_cnt_inc;
                    end else if (r_pre == c_PRE_MAX) begin
                        r_pre <= '0;
                    end else begin
                        r_pre <= r_pre + c_PRE_ONE;
                    end
                end
                ST_HOLD: begin
                    r_pre <= '0;
                    if (w_any_edge) begin
                        r_src <= r_src | w_edge;
                        if (RETRIG != 0) begin
                            r_hold <= c_HOLD_LOAD;
                        end else if (r_hold != '0) begin
                            r_hold <= r_hold - c_HOLD_ONE;
                        end
                    end else begin
                        if (r_hold != '0) begin
                            r_hold <= r_hold - c_HOLD_ONE;
                        end
                        // A level still held keeps the game diverted past expiry.
                        if ((r_hold == '0) && (divert_req == '0)) begin
                            r_state <= ST_RESUME;
                        end
                    end
                end
                ST_RESUME: begin
                    r_pre <= '0;
                    if (w_any_edge) begin
                        r_state <= ST_HOLD;
                        r_hold  <= c_HOLD_LOAD;
                        r_src   <= w_edge;
                        r_cnt   <= w_cnt_inc;
                    end else begin
                        r_state  <= ST_RUN;
                        r_paused <= 1'b0;
                        r_src    <= '0;
                    end
                end
                default: begin
                    r_state  <= ST_RUN;
                    r_paused <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_clock_divert_ctrl.sv
// Scoreboard bench for clock_divert_ctrl: pulse and snapshot expectations are
// queued by the stimulus and consumed by per-instance monitors.
`timescale 1ns/1ps
`default_nettype none

module tb_clock_divert_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rst_b = 1'b0;
    logic [1:0] req_a = 2'b00;
    logic [1:0] req_b = 2'b00;

    logic       tick_a, paused_a, resume_a;
    logic [1:0] src_a;
    logic [7:0] cnt_a;
    logic       tick_b, paused_b, resume_b;
    logic [1:0] src_b;
    logic [7:0] cnt_b;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; bit is_resume; } ev_t;
    typedef struct { int cyc; bit paused; logic [1:0] src; logic [7:0] cnt; } snap_t;

    ev_t   evq_a[$];
    ev_t   evq_b[$];
    snap_t snq_a[$];
    snap_t snq_b[$];

    clock_divert_ctrl #(.DIV(4), .HOLD_CYCLES(10), .NCH(2), .RETRIG(1)) dut (
        .clk(clk), .rst_n(rst_n), .divert_req(req_a), .tick(tick_a),
        .paused(paused_a), .pause_src(src_a), .resume(resume_a), .pause_cnt(cnt_a)
    );

    clock_divert_ctrl #(.DIV(4), .HOLD_CYCLES(10), .NCH(2), .RETRIG(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .divert_req(req_b), .tick(tick_b),
        .paused(paused_b), .pause_src(src_b), .resume(resume_b), .pause_cnt(cnt_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void ev_a(int c, bit r);
        ev_t e; e.cyc = c; e.is_resume = r; evq_a.push_back(e);
    endfunction
    function automatic void ev_b(int c, bit r);
        ev_t e; e.cyc = c; e.is_resume = r; evq_b.push_back(e);
    endfunction
    function automatic void sn_a(int c, bit p, logic [1:0] s, logic [7:0] n);
        snap_t x; x.cyc = c; x.paused = p; x.src = s; x.cnt = n; snq_a.push_back(x);
    endfunction
    function automatic void sn_b(int c, bit p, logic [1:0] s, logic [7:0] n);
        snap_t x; x.cyc = c; x.paused = p; x.src = s; x.cnt = n; snq_b.push_back(x);
    endfunction

    // Monitor for instance A (RETRIG=1)
    ev_t   ma_e;
    snap_t ma_s;
    always @(negedge clk) begin
        if (tick_a || resume_a) begin
            checks++;
            if (evq_a.size() == 0) begin
                errors++;
                $display("FAIL pulse_a: got tick=%0d resume=%0d at cycle %0d, required no pulse",
                         tick_a, resume_a, cyc);
            end else begin
                ma_e = evq_a.pop_front();
                if (ma_e.cyc != cyc || (tick_a && resume_a) || (resume_a != ma_e.is_resume)) begin
                    errors++;
                    $display("FAIL pulse_a: got tick=%0d resume=%0d at cycle %0d, required %s at cycle %0d",
                             tick_a, resume_a, cyc, ma_e.is_resume ? "resume" : "tick", ma_e.cyc);
                end
            end
        end
        while (snq_a.size() > 0 && snq_a[0].cyc < cyc) begin
            ma_s = snq_a.pop_front();
            checks++; errors++;
            $display("FAIL snap_a: snapshot for cycle %0d never sampled", ma_s.cyc);
        end
        if (snq_a.size() > 0 && snq_a[0].cyc == cyc) begin
            ma_s = snq_a.pop_front();
            checks++;
            if (paused_a !== ma_s.paused || src_a !== ma_s.src || cnt_a !== ma_s.cnt) begin
                errors++;
                $display("FAIL snap_a cycle %0d: got paused=%0d src=%b cnt=%0d, required paused=%0d src=%b cnt=%0d",
                         cyc, paused_a, src_a, cnt_a, ma_s.paused, ma_s.src, ma_s.cnt);
            end
        end
    end

    // Monitor for instance B (RETRIG=0)
    ev_t   mb_e;
    snap_t mb_s;
    always @(negedge clk) begin
        if (tick_b || resume_b) begin
            checks++;
            if (evq_b.size() == 0) begin
                errors++;
                $display("FAIL pulse_b: got tick=%0d resume=%0d at cycle %0d, required no pulse",
                         tick_b, resume_b, cyc);
            end else begin
                mb_e = evq_b.pop_front();
                if (mb_e.cyc != cyc || (tick_b && resume_b) || (resume_b != mb_e.is_resume)) begin
                    errors++;
                    $display("FAIL pulse_b: got tick=%0d resume=%0d at cycle %0d, required %s at cycle %0d",
                             tick_b, resume_b, cyc, mb_e.is_resume ? "resume" : "tick", mb_e.cyc);
                end
            end
        end
        while (snq_b.size() > 0 && snq_b[0].cyc < cyc) begin
            mb_s = snq_b.pop_front();
            checks++; errors++;
            $display("FAIL snap_b: snapshot for cycle %0d never sampled", mb_s.cyc);
        end
        if (snq_b.size() > 0 && snq_b[0].cyc == cyc) begin
            mb_s = snq_b.pop_front();
            checks++;
            if (paused_b !== mb_s.paused || src_b !== mb_s.src || cnt_b !== mb_s.cnt) begin
                errors++;
                $display("FAIL snap_b cycle %0d: got paused=%0d src=%b cnt=%0d, required paused=%0d src=%b cnt=%0d",
                         cyc, paused_b, src_b, cnt_b, mb_s.paused, mb_s.src, mb_s.cnt);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    // The edge on req_a masks any pulse in the cycle the reset is applied.
    task automatic do_reset(output int base);
        rst_n = 1'b0;
        req_a = 2'b01;
        step();
        req_a = 2'b00;
        rst_n = 1'b1;
        base  = cyc;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b, t, u, v, bb;
        repeat (3) step();

        // Free run, then a single pulse landing on a tick cycle.
        do_reset(b);
        t = b + 23;
        sn_a(b, 0, 2'b00, 8'd0);
        sn_a(b + 10, 0, 2'b00, 8'd0);
        for (int k = 0; k < 5; k++) ev_a(b + 3 + 4 * k, 0);
        for (int i = 0; i <= 12; i++)
            sn_a(t + i, (i >= 1 && i <= 11), (i >= 1 && i <= 11) ? 2'b01 : 2'b00, (i >= 1) ? 8'd1 : 8'd0);
        ev_a(t + 11, 1);
        ev_a(t + 15, 0);
        ev_a(t + 19, 0);
        wait_until(t);      req_a = 2'b01;
        wait_until(t + 1);  req_a = 2'b00;
        wait_until(t + 20);

        // Retrigger with RETRIG=1.
        do_reset(b);
        u = b + 4;
        ev_a(b + 3, 0);
        sn_a(u, 0, 2'b00, 8'd0);
        sn_a(u + 1, 1, 2'b01, 8'd1);
        sn_a(u + 6, 1, 2'b01, 8'd1);
        sn_a(u + 7, 1, 2'b11, 8'd1);
        sn_a(u + 12, 1, 2'b11, 8'd1);
        sn_a(u + 17, 1, 2'b11, 8'd1);
        sn_a(u + 18, 0, 2'b00, 8'd1);
        ev_a(u + 17, 1);
        ev_a(u + 21, 0);
        ev_a(u + 25, 0);
        wait_until(u);      req_a = 2'b01;
        wait_until(u + 1);  req_a = 2'b00;
        wait_until(u + 6);  req_a = 2'b10;
        wait_until(u + 7);  req_a = 2'b00;
        wait_until(u + 26);

        // Retrigger with RETRIG=0 on instance B while A sits in reset.
        rst_n = 1'b0;
        req_a = 2'b01;
        step();
        req_a = 2'b00;
        rst_b = 1'b1;
        bb = cyc;
        v = bb + 4;
        ev_b(bb + 3, 0);
        sn_b(bb, 0, 2'b00, 8'd0);
        sn_b(v + 1, 1, 2'b01, 8'd1);
        sn_b(v + 7, 1, 2'b11, 8'd1);
        sn_b(v + 11, 1, 2'b11, 8'd1);
        sn_b(v + 12, 0, 2'b00, 8'd1);
        ev_b(v + 11, 1);
        ev_b(v + 15, 0);
        ev_b(v + 19, 0);
        wait_until(v);      req_b = 2'b01;
        wait_until(v + 1);  req_b = 2'b00;
        wait_until(v + 6);  req_b = 2'b10;
        wait_until(v + 7);  req_b = 2'b00;
        wait_until(v + 20); rst_b = 1'b0;

        // Request held high for 30 cycles.
        do_reset(b);
        u = b + 4;
        ev_a(b + 3, 0);
        sn_a(u + 1, 1, 2'b01, 8'd1);
        sn_a(u + 29, 1, 2'b01, 8'd1);
        sn_a(u + 30, 1, 2'b01, 8'd1);
        sn_a(u + 31, 1, 2'b01, 8'd1);
        sn_a(u + 32, 0, 2'b00, 8'd1);
        ev_a(u + 31, 1);
        ev_a(u + 35, 0);
        ev_a(u + 39, 0);
        wait_until(u);      req_a = 2'b01;
        wait_until(u + 30); req_a = 2'b00;
        wait_until(u + 40);

        // Edge during RESUME, then chained pauses up to saturation.
        do_reset(b);
        u = b + 4;
        ev_a(b + 3, 0);
        sn_a(u + 11, 1, 2'b01, 8'd1);
        sn_a(u + 12, 1, 2'b10, 8'd2);
        sn_a(u + 22, 1, 2'b10, 8'd2);
        sn_a(u + 23, 0, 2'b00, 8'd2);
        ev_a(u + 22, 1);
        ev_a(u + 26, 0);
        v = u + 27;   // edge of pause #3; pause #k edges at v + 11*(k-3)
        sn_a(v + 11 * 251 + 1, 1, 2'b01, 8'd254);
        sn_a(v + 11 * 252 + 1, 1, 2'b01, 8'd255);
        sn_a(v + 11 * 297 + 1, 1, 2'b01, 8'd255);
        sn_a(v + 11 * 297 + 11, 1, 2'b01, 8'd255);
        sn_a(v + 11 * 297 + 12, 0, 2'b00, 8'd255);
        ev_a(v + 11 * 297 + 11, 1);
        ev_a(v + 11 * 297 + 15, 0);
        wait_until(u);      req_a = 2'b01;
        wait_until(u + 1);  req_a = 2'b00;
        wait_until(u + 11); req_a = 2'b10;
        wait_until(u + 12); req_a = 2'b00;
        for (int k = 3; k <= 300; k++) begin
            wait_until(v + 11 * (k - 3));     req_a = 2'b01;
            wait_until(v + 11 * (k - 3) + 1); req_a = 2'b00;
        end
        wait_until(v + 11 * 297 + 16);

        // One-cycle reset mid-HOLD with the request high across release.
        do_reset(b);
        u = b + 4;
        ev_a(b + 3, 0);
        sn_a(u + 5, 1, 2'b01, 8'd1);
        sn_a(u + 6, 0, 2'b00, 8'd0);
        sn_a(u + 7, 1, 2'b01, 8'd1);
        sn_a(u + 18, 0, 2'b00, 8'd1);
        ev_a(u + 17, 1);
        ev_a(u + 21, 0);
        wait_until(u);      req_a = 2'b01;
        wait_until(u + 1);  req_a = 2'b00;
        wait_until(u + 5);  req_a = 2'b01; rst_n = 1'b0;
        wait_until(u + 6);  rst_n = 1'b1;
        wait_until(u + 8);  req_a = 2'b00;
        wait_until(u + 23);

        while (evq_a.size() > 0) begin
            ev_t e; e = evq_a.pop_front(); checks++; errors++;
            $display("FAIL pulse_a: required %s at cycle %0d never seen", e.is_resume ? "resume" : "tick", e.cyc);
        end
        while (evq_b.size() > 0) begin
            ev_t e; e = evq_b.pop_front(); checks++; errors++;
            $display("FAIL pulse_b: required %s at cycle %0d never seen", e.is_resume ? "resume" : "tick", e.cyc);
        end
        while (snq_a.size() > 0) begin
            snap_t s; s = snq_a.pop_front(); checks++; errors++;
            $display("FAIL snap_a: snapshot for cycle %0d never sampled", s.cyc);
        end
        while (snq_b.size() > 0) begin
            snap_t s; s = snq_b.pop_front(); checks++; errors++;
            $display("FAIL snap_b: snapshot for cycle %0d never sampled", s.cyc);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/clock_divert_ctrl.md
CLOCK_DIVERT_CTRL -- requirements
Module: clock_divert_ctrl

Interface
REQ-001 Parameter DIV, default 4: tick period in clk cycles; SHALL be >= 2.
REQ-002 Parameter HOLD_CYCLES, default 104160: minimum pause length in clk cycles, one UART frame at 100 MHz / 9600 baud; SHALL be >= 1.
REQ-003 Parameter NCH, default 2: number of divert request channels; SHALL be >= 1.
REQ-004 Parameter RETRIG, default 1: 1 means a new request during a pause reloads the hold counter; 0 means it is only recorded.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 rst_n  input  1  synchronous, active-low reset.
REQ-007 divert_req  input  NCH  per-channel divert request, level; a rising edge starts or extends a pause.
REQ-008 tick  output  1  single-cycle game clock-enable pulse.
REQ-009 paused  output  1  high while the game is diverted (HOLD or RESUME state).
REQ-010 pause_src  output  NCH  sticky record of channels that caused or extended the current pause.
REQ-011 resume  output  1  single-cycle pulse when a pause ends.
REQ-012 pause_cnt  output  8  saturating count of pauses entered since reset.

Function
REQ-013 Registers SHALL be: state (RUN, HOLD, RESUME), prescaler of width clog2(DIV), hold counter of width clog2(HOLD_CYCLES+1), previous divert_req, pause_src, and pause_cnt.
REQ-014 Edge detect: edge[i] = divert_req[i] & ~prev[i]; prev SHALL update every cycle; any_edge = OR of edge.
REQ-015 RUN, no any_edge: prescaler counts 0..DIV-1 and wraps to 0; tick = 1 exactly in cycles where prescaler == DIV-1.
REQ-016 RUN with any_edge: next state HOLD; hold counter loads HOLD_CYCLES-1; prescaler clears; pause_src loads edge; pause_cnt increments, saturating at 255; tick SHALL be 0 in this cycle even if prescaler == DIV-1.
REQ-017 HOLD: hold counter decrements by 1 per cycle while nonzero and holds at 0; prescaler holds at 0; tick = 0.
REQ-018 HOLD with any_edge: pause_src ORs in edge; if RETRIG = 1, hold counter reloads HOLD_CYCLES-1; pause_cnt does not change.
REQ-019 HOLD exit: when hold counter == 0, no any_edge, and divert_req == 0, next state is RESUME; while any divert_req bit stays high, remain in HOLD.
REQ-020 RESUME lasts one cycle with resume = 1 and tick = 0; next state RUN; pause_src clears to 0; prescaler 0.
REQ-021 any_edge in RESUME: next state HOLD with the REQ-016 loads; resume = 0 in that cycle; pause_src loads edge; pause_cnt increments.
REQ-022 First tick after RESUME SHALL occur DIV cycles after the first RUN cycle.
REQ-023 paused SHALL be a registered function of state, high in HOLD and RESUME; tick and resume are combinational from registered state and prescaler only.
REQ-024 Pause length from the triggering edge cycle to the resume cycle, with the request released and no retrigger, SHALL be HOLD_CYCLES+1 cycles.

Reset
REQ-025 rst_n = 0 at a clk edge SHALL set: state RUN, prescaler 0, hold counter 0, prev 0, pause_src 0, pause_cnt 0; outputs tick 0, paused 0, resume 0.
REQ-026 Reset SHALL take priority over every other event, including mid-HOLD and mid-RESUME.
REQ-027 A divert_req bit already high when rst_n releases SHALL count as a rising edge, because prev resets to 0.

Verification (DIV=4, HOLD_CYCLES=10, NCH=2, RETRIG=1 unless noted)
REQ-028 Free run, no requests, 20 cycles after reset -> tick high in cycles 3, 7, 11, 15, 19; paused 0.
REQ-029 1-cycle pulse on divert_req[0] at prescaler 3 -> no tick in that cycle; paused high for 11 cycles; resume once; pause_src = 01 throughout the pause; pause_cnt = 1; next tick 4 cycles after RUN resumes.
REQ-030 Retrigger: divert_req[1] pulse 6 cycles into a pause -> pause extended to end 11 cycles after the retrigger; pause_src = 11; pause_cnt unchanged. With RETRIG=0 -> pause ends at the original time; pause_src = 11.
REQ-031 divert_req[0] held high for 30 cycles -> paused stays high until the cycle after the release, then RESUME; resume pulses exactly once.
REQ-032 Edge in the RESUME cycle -> resume stays 0; back to HOLD; pause_cnt +1. Drive 300 separate pauses -> pause_cnt saturates at 255.
REQ-033 rst_n low for 1 cycle mid-HOLD -> all outputs 0, no tick, RUN state; with divert_req[0] high at release -> new pause begins and pause_cnt = 1.
